// File: rtl/step_run_ctrl.sv
// step_run_ctrl: single-step / free-run / PC-breakpoint controller that gates the CPU clock enable.
module step_run_ctrl #(
  parameter int RATE  = 25000000,
  parameter int DIV_W = 26,
  parameter int PC_W  = 32,
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             BTN_STEP,
  input  logic             BTN_RUN,
  input  logic             BP_EN,
  input  logic [PC_W-1:0]  BP_ADDR,
  input  logic [PC_W-1:0]  PC,
  output logic             CPU_CE,
  output logic [1:0]       MODE,
  output logic             HALTED,
  output logic [CNT_W-1:0] STEP_CNT
);
  localparam logic [1:0] S_STOP = 2'b00, S_STEP = 2'b01, S_RUN = 2'b10, S_BREAK = 2'b11;
  localparam logic [DIV_W-1:0] LAST = DIV_W'(RATE - 1);
  logic [1:0] state_q, state_d;
  // bit 0 holds the latest button sample, bit 1 the one before it
  logic [1:0] step_q, run_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic ce_q, ce_d, skip_q, skip_d;
  logic step_e, run_e, tick, bp_hit;
  assign step_e = step_q[0] & ~step_q[1];
  assign run_e  = run_q[0] & ~run_q[1];
  assign tick   = div_q == LAST;
  assign bp_hit = BP_EN && (PC == BP_ADDR) && !skip_q;
  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    skip_d  = skip_q;
    ce_d    = 1'b0;
    case (state_q)
      S_STOP: begin
        if (run_e) begin
          state_d = S_RUN;
          div_d   = '0;
        end else if (step_e) begin
          state_d = S_STEP;
          ce_d    = 1'b1;
        end
      end
      S_STEP: state_d = S_STOP;
      S_RUN: begin
        if (run_e) state_d = S_STOP;
        else begin
          div_d = tick ? '0 : div_q + 1'b1;
          if (tick && bp_hit) state_d = S_BREAK;
          else if (tick) begin
            ce_d   = 1'b1;
            skip_d = 1'b0;
          end
        end
      end
      default: begin
        // resuming from a breakpoint must execute the instruction sitting on it
        if (run_e) begin
          state_d = S_RUN;
          div_d   = '0;
          skip_d  = 1'b1;
        end else if (step_e) begin
          state_d = S_STEP;
          ce_d    = 1'b1;
        end
      end
    endcase
    cnt_d = cnt_q + CNT_W'(ce_d);
  end
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_STOP;
      step_q  <= 2'b11;
      run_q   <= 2'b11;
      div_q   <= '0;
      cnt_q   <= '0;
      ce_q    <= 1'b0;
      skip_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      step_q  <= {step_q[0], BTN_STEP};
      run_q   <= {run_q[0], BTN_RUN};
      div_q   <= div_d;
      cnt_q   <= cnt_d;
      ce_q    <= ce_d;
      skip_q  <= skip_d;
    end
  end
  assign CPU_CE   = ce_q;
  assign MODE     = state_q;
  assign HALTED   = state_q == S_BREAK;
  assign STEP_CNT = cnt_q;
endmodule

// File: tb/tb_step_run_ctrl.sv
// tb_step_run_ctrl: cycle-by-cycle vectors for step_run_ctrl (RATE=4, CNT_W=4), checked through a scoreboard queue.
module tb_step_run_ctrl;
  localparam logic [1:0] STOP = 2'b00, STEP = 2'b01, RUN = 2'b10, BRK = 2'b11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic btn_step, btn_run, bp_en;
  logic [31:0] pc;
  logic [31:0] bp_addr = 32'h0000_000C;
  logic cpu_ce, halted;
  logic [1:0] mode;
  logic [3:0] step_cnt;
  int n_chk = 0;
  int n_fail = 0;
  typedef struct {
    string tag;
    logic s, r, bp;
    logic [31:0] pc;
    int rep;
    logic ce;
    logic [1:0] mode;
    logic h;
    logic [3:0] cnt;
  } vec_t;
  typedef struct {
    string tag;
    logic ce;
    logic [1:0] mode;
    logic h;
    logic [3:0] cnt;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];

  step_run_ctrl #(.RATE(4), .DIV_W(26), .PC_W(32), .CNT_W(4)) dut (
    .CLK(clk), .RST(rst_n), .BTN_STEP(btn_step), .BTN_RUN(btn_run), .BP_EN(bp_en),
    .BP_ADDR(bp_addr), .PC(pc), .CPU_CE(cpu_ce), .MODE(mode), .HALTED(halted), .STEP_CNT(step_cnt)
  );

  always #5 clk = ~clk;

  task automatic add(input string tag, input logic s, input logic r, input logic bp, input logic [31:0] p,
                     input int rep, input logic ce, input logic [1:0] m, input logic h, input logic [3:0] c);
    vec_t v;
    v.tag = tag; v.s = s; v.r = r; v.bp = bp; v.pc = p; v.rep = rep;
    v.ce = ce; v.mode = m; v.h = h; v.cnt = c;
    tbl.push_back(v);
  endtask

  task automatic push_exp(input string tag, input logic ce, input logic [1:0] m, input logic h, input logic [3:0] c);
    exp_t e;
    e.tag = tag; e.ce = ce; e.mode = m; e.h = h; e.cnt = c;
    sb.push_back(e);
  endtask

  task automatic compare();
    exp_t e;
    e = sb.pop_front();
    n_chk++;
    if ({cpu_ce, mode, halted, step_cnt} !== {e.ce, e.mode, e.h, e.cnt}) begin
      n_fail++;
      $display("FAIL %s @%0t: got ce=%b mode=%b halted=%b cnt=%0d, expected ce=%b mode=%b halted=%b cnt=%0d",
               e.tag, $time, cpu_ce, mode, halted, step_cnt, e.ce, e.mode, e.h, e.cnt);
    end
  endtask

  // drive one cycle of inputs, then check the outputs registered at the following edge
  task automatic cyc(input string tag, input logic s, input logic r, input logic bp, input logic [31:0] p,
                     input logic ce, input logic [1:0] m, input logic h, input logic [3:0] c);
    btn_step = s; btn_run = r; bp_en = bp; pc = p;
    push_exp(tag, ce, m, h, c);
    @(posedge clk);
    #1;
    compare();
  endtask

  initial begin
    btn_step = 1'b1; btn_run = 1'b0; bp_en = 1'b0; pc = '0;
    repeat (3) @(posedge clk);
    #1;
    push_exp("in_reset", 1'b0, STOP, 1'b0, 4'd0);
    compare();
    rst_n = 1'b1;

    add("held_thru_reset", 1, 0, 0, 32'h0, 1, 0, STOP, 0, 0);
    add("step_release",    0, 0, 0, 32'h0, 1, 0, STOP, 0, 0);
    add("step_edge",       1, 0, 0, 32'h0, 1, 0, STOP, 0, 0);
    add("step_pulse",      1, 0, 0, 32'h0, 1, 1, STEP, 0, 1);
    add("step_back",       1, 0, 0, 32'h0, 1, 0, STOP, 0, 1);
    add("step_idle",       0, 0, 0, 32'h0, 1, 0, STOP, 0, 1);
    add("run_edge",        0, 1, 0, 32'h0, 1, 0, STOP, 0, 1);
    add("run_enter",       0, 1, 0, 32'h0, 1, 0, RUN,  0, 1);
    for (int p = 0; p < 4; p++) begin
      add("run_wait",  0, 1, 0, 32'h0, 3, 0, RUN, 0, 4'(p + 1));
      add("run_pulse", 0, 1, 0, 32'h0, 1, 1, RUN, 0, 4'(p + 2));
    end
    add("run_release",     0, 0, 0, 32'h0, 2, 0, RUN,  0, 5);
    add("stop_on_tick",    0, 1, 0, 32'h0, 1, 0, RUN,  0, 5);
    add("stop_no_pulse",   0, 1, 0, 32'h0, 1, 0, STOP, 0, 5);
    add("stop_idle",       0, 0, 0, 32'h0, 2, 0, STOP, 0, 5);
    add("bp_run_edge",     0, 1, 1, 32'h0, 1, 0, STOP, 0, 5);
    add("bp_run",          0, 1, 1, 32'h0, 2, 0, RUN,  0, 5);
    add("bp_run",          0, 0, 1, 32'h0, 2, 0, RUN,  0, 5);
    add("bp_pc0",          0, 0, 1, 32'h0, 1, 1, RUN,  0, 6);
    add("bp_wait",         0, 0, 1, 32'h0, 1, 0, RUN,  0, 6);
    add("bp_wait",         0, 0, 1, 32'h4, 2, 0, RUN,  0, 6);
    add("bp_pc4",          0, 0, 1, 32'h4, 1, 1, RUN,  0, 7);
    add("bp_wait",         0, 0, 1, 32'h4, 1, 0, RUN,  0, 7);
    add("bp_wait",         0, 0, 1, 32'h8, 2, 0, RUN,  0, 7);
    add("bp_pc8",          0, 0, 1, 32'h8, 1, 1, RUN,  0, 8);
    add("bp_wait",         0, 0, 1, 32'h8, 1, 0, RUN,  0, 8);
    add("bp_wait",         0, 0, 1, 32'hC, 2, 0, RUN,  0, 8);
    add("bp_hit",          0, 0, 1, 32'hC, 1, 0, BRK,  1, 8);
    add("bp_halted_bpoff", 0, 0, 0, 32'hC, 6, 0, BRK,  1, 8);
    add("bp_resume_edge",  0, 1, 1, 32'hC, 1, 0, BRK,  1, 8);
    add("bp_resume",       0, 1, 1, 32'hC, 1, 0, RUN,  0, 8);
    add("bp_skip_wait",    0, 0, 1, 32'hC, 3, 0, RUN,  0, 8);
    add("bp_skip_pulse",   0, 0, 1, 32'hC, 1, 1, RUN,  0, 9);
    add("bp_after",        0, 0, 1, 32'hC, 1, 0, RUN,  0, 9);
    add("bp_stop_edge",    0, 1, 1, 32'h10, 1, 0, RUN, 0, 9);
    add("bp_stop",         0, 1, 1, 32'h10, 1, 0, STOP, 0, 9);
    add("bp_stop_idle",    0, 0, 1, 32'h10, 1, 0, STOP, 0, 9);
    add("both_stop_edge",  1, 1, 1, 32'hC, 1, 0, STOP, 0, 9);
    add("both_stop_run",   1, 1, 1, 32'hC, 1, 0, RUN,  0, 9);
    add("both_wait",       0, 0, 1, 32'hC, 3, 0, RUN,  0, 9);
    add("both_break",      0, 0, 1, 32'hC, 1, 0, BRK,  1, 9);
    add("both_brk_edge",   1, 1, 1, 32'hC, 1, 0, BRK,  1, 9);
    add("both_brk_run",    1, 1, 1, 32'hC, 1, 0, RUN,  0, 9);
    add("loop_wait",       0, 0, 1, 32'hC, 3, 0, RUN,  0, 9);
    add("loop_skip_pulse", 0, 0, 1, 32'hC, 1, 1, RUN,  0, 10);
    add("loop_wait",       0, 0, 1, 32'hC, 1, 0, RUN,  0, 10);
    add("loop_wait",       0, 0, 1, 32'h10, 2, 0, RUN, 0, 10);
    add("loop_pulse",      0, 0, 1, 32'h10, 1, 1, RUN, 0, 11);
    add("loop_wait",       0, 0, 1, 32'h10, 1, 0, RUN, 0, 11);
    add("loop_wait",       0, 0, 1, 32'hC, 2, 0, RUN,  0, 11);
    add("loop_rebreak",    0, 0, 1, 32'hC, 1, 0, BRK,  1, 11);
    add("brk_idle",        0, 0, 1, 32'hC, 1, 0, BRK,  1, 11);
    add("brk_step_edge",   1, 0, 1, 32'hC, 1, 0, BRK,  1, 11);
    add("brk_step",        1, 0, 1, 32'hC, 1, 1, STEP, 0, 12);
    add("brk_step_done",   0, 0, 1, 32'hC, 2, 0, STOP, 0, 12);

    foreach (tbl[i])
      repeat (tbl[i].rep)
        cyc(tbl[i].tag, tbl[i].s, tbl[i].r, tbl[i].bp, tbl[i].pc, tbl[i].ce, tbl[i].mode, tbl[i].h, tbl[i].cnt);

    cyc("rst_run_edge", 0, 1, 0, 32'h0, 0, STOP, 0, 12);
    cyc("rst_run_enter", 0, 1, 0, 32'h0, 0, RUN, 0, 12);
    repeat (3) cyc("rst_run_wait", 0, 1, 0, 32'h0, 0, RUN, 0, 12);
    cyc("rst_run_pulse", 0, 1, 0, 32'h0, 1, RUN, 0, 13);
    rst_n = 1'b0;
    #1;
    push_exp("async_reset", 1'b0, STOP, 1'b0, 4'd0);
    compare();
    #1 rst_n = 1'b1;
    repeat (8) cyc("no_edge_after_reset", 0, 1, 0, 32'h0, 0, STOP, 0, 0);
    cyc("run_release", 0, 0, 0, 32'h0, 0, STOP, 0, 0);

    for (int k = 1; k <= 17; k++) begin
      cyc("wrap_edge", 1, 0, 0, 32'h0, 0, STOP, 0, 4'(k - 1));
      cyc("wrap_step", 1, 0, 0, 32'h0, 1, STEP, 0, 4'(k));
      cyc("wrap_idle", 0, 0, 0, 32'h0, 0, STOP, 0, 4'(k));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/step_run_ctrl.md
Name: step_run_ctrl

Overview:
- Execution controller directly upstream of SingleClockMIPS.
- Takes debounced button levels from the button-conditioning stage and decides when the processor advances. The processor clocks on CLK and updates PC/registers only in cycles where CPU_CE=1.
- Three execution modes: single-step, free-run at a programmable rate, and PC-breakpoint halt, so programs can be traced on the board.

Parameters:
- RATE, 25000000: CLK cycles per instruction in RUN mode (0.5 s at 50 MHz); legal range 2..2^DIV_W-1.
- DIV_W, 26: prescaler counter width.
- PC_W, 32: PC / breakpoint address width.
- CNT_W, 16: executed-instruction counter width.

Ports:
- CLK  in  1  system clock (50 MHz).
- RST  in  1  asynchronous, active-low reset.
- BTN_STEP  in  1  debounced step-button level, high = pressed.
- BTN_RUN  in  1  debounced run/stop-button level, high = pressed.
- BP_EN  in  1  breakpoint enable.
- BP_ADDR  in  PC_W  breakpoint address.
- PC  in  PC_W  current processor PC.
- CPU_CE  out  1  processor clock enable, one-cycle pulse per instruction.
- MODE  out  2  current state encoding: 00 STOP, 01 STEP, 10 RUN, 11 BREAK.
- HALTED  out  1  high while in BREAK.
- STEP_CNT  out  CNT_W  number of CPU_CE pulses issued since reset.

Behaviour:

Reset:
- RST low asynchronously forces state=STOP, CPU_CE=0, HALTED=0, MODE=00, STEP_CNT=0, prescaler=0, skip_bp=0.
- Both button history registers reset to 1, so a button held through reset produces no edge.
- Reset mid-pulse kills CPU_CE immediately.

Edge detection:
- Each button is registered once per cycle.
- An edge is the current sample = 1 while the previous sample = 0.
- Exactly one edge per press, regardless of hold time.

FSM (all outputs registered):
- STOP:
  - run edge -> RUN; prescaler cleared.
  - step edge (with no run edge) -> STEP.
  - If both edges arrive in the same cycle, run wins.
- STEP:
  - CPU_CE=1 for exactly this one cycle.
  - STEP_CNT increments.
  - Next state STOP unconditionally; buttons are ignored in this cycle.
- RUN:
  - Prescaler counts 0..RATE-1, then wraps to 0.
  - At count RATE-1 (the "tick"):
    - If BP_EN=1, PC==BP_ADDR and skip_bp=0 -> BREAK, no pulse.
    - Otherwise CPU_CE=1 next cycle, STEP_CNT increments, skip_bp cleared.
  - run edge -> STOP. This has priority over a tick in the same cycle: no pulse is issued.
  - step edges are ignored.
- BREAK:
  - HALTED=1.
  - step edge -> STEP, which executes the breakpoint instruction and then returns to STOP.
  - run edge -> RUN with skip_bp=1 and prescaler cleared, so the first tick executes even though PC==BP_ADDR.
  - Run wins over step.
  - Clearing BP_EN does not leave BREAK; only a button edge does.

Timing and counters:
- Latency: a button rising at edge k (sampled 1 after 0) causes the state change at edge k+1. CPU_CE is high between edges k+1 and k+2.
- CPU_CE is never high for two consecutive cycles.
- In RUN, the pulse period is exactly RATE cycles.
- STEP_CNT wraps from all-ones to 0 silently.
- PC and BP_ADDR are compared over full PC_W bits, unsigned equality.

Test Plan:
1. RST=0 then 1 with BTN_STEP held at 1 -> no CPU_CE, MODE=00, STEP_CNT=0. Release and press BTN_STEP -> exactly one CPU_CE pulse two cycles after the sampled edge; STEP_CNT=1; MODE returns to 00.
2. RATE=4: press BTN_RUN, hold for 20 cycles -> CPU_CE pulses every 4 cycles; MODE=10. Press BTN_RUN again on the tick cycle -> no pulse, MODE=00.
3. RATE=4, BP_EN=1, BP_ADDR=0x0000000C, PC stepping 0,4,8,C with each pulse -> 3 pulses, then MODE=11 and HALTED=1 with PC=0x0C and no further pulses. Press BTN_RUN -> next tick pulses (PC advances to 0x10); HALTED=0.
4. BTN_STEP and BTN_RUN rising in the same cycle from STOP -> MODE=10, no step pulse. Same stimulus in BREAK -> RUN. In BREAK with a step edge only -> one pulse, MODE=00.
5. CNT_W=4: issue 17 steps -> STEP_CNT reads 15 after the 15th step, 0 after the 16th, 1 after the 17th.
6. Assert RST low during the RUN pulse cycle -> CPU_CE drops without waiting for CLK; all outputs at reset values. After release, no pulse until a new button edge.
